// File: rtl/bp_mem_cmd_responder.sv
// bp_mem_cmd_responder
// Test-side memory model at the far end of the cce_mem interface. It accepts
// one mem_cmd at a time and returns the matching mem_resp a programmable
// number of cycles later. The backing store holds whole cache blocks and
// serves cached and uncached reads and writes.
//
// Message layout, MSB to LSB:
//   {msg_type[3:0], addr[paddr_width_p-1:0], size[2:0],
//    payload[payload_width_p-1:0], data[cce_block_width_p-1:0]}
// msg_type encodings: rd=0, wr=1, uc_rd=2, uc_wr=3. Any other value is
// served as a cached block read with no state change.
//
// Optional feature: define BP_MEM_RESPONDER_RANDOM_LATENCY_EN to add
// 0..7 cycles of LFSR-driven extra latency on each accepted command.
//
// Handshake rules: a command transfers on a rising edge where
// mem_cmd_v_i & mem_cmd_ready_o. A response is offered with mem_resp_v_o
// and held unchanged until the consumer pulses mem_resp_yumi_i, which is
// only legal while mem_resp_v_o is high.
module bp_mem_cmd_responder #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int payload_width_p   = 16,
    parameter int mem_els_p         = 1024,
    parameter int latency_p         = 4,
    localparam int cce_mem_msg_width_lp =
        4 + paddr_width_p + 3 + payload_width_p + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i,
    output logic [1:0]                      state_o
);

    localparam int block_bytes_lp    = cce_block_width_p / 8;
    localparam int lg_block_bytes_lp = $clog2(block_bytes_lp);
    localparam int lg_mem_els_lp     = $clog2(mem_els_p);
    localparam int cnt_width_lp      = $clog2(latency_p + 8) + 1;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'd0,
        e_mem_msg_wr    = 4'd1,
        e_mem_msg_uc_rd = 4'd2,
        e_mem_msg_uc_wr = 4'd3
    } mem_msg_type_e;

    typedef struct packed {
        logic [3:0]                   msg_type;
        logic [paddr_width_p-1:0]     addr;
        logic [2:0]                   size;
        logic [payload_width_p-1:0]   payload;
        logic [cce_block_width_p-1:0] data;
    } mem_msg_s;

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_ready = 2'd1,
        e_wait  = 2'd2,
        e_resp  = 2'd3
    } state_e;

    localparam logic [cnt_width_lp-1:0] cnt_one = cnt_width_lp'(1);

    // Command view and FSM registers
    mem_msg_s                     cmd;
    mem_msg_s                     resp_r;
    state_e                       state;
    logic [cnt_width_lp-1:0]      cnt;
    logic                         ready_r;
    logic                         resp_v_r;

    // Datapath between the command and the backing store
    logic                         accept;
    logic                         is_write;
    logic                         known_type;
    logic                         wr_en;
    logic [lg_mem_els_lp-1:0]     blk_idx;
    logic [lg_block_bytes_lp-1:0] byte_off;
    logic [2:0]                   size_eff;
    logic [31:0]                  nbytes;
    logic [block_bytes_lp-1:0]    size_mask;
    logic [block_bytes_lp-1:0]    wr_mask;
    logic [cce_block_width_p-1:0] rd_block;
    logic [cce_block_width_p-1:0] rd_shift;
    logic [cce_block_width_p-1:0] uc_rd_data;
    logic [cce_block_width_p-1:0] wr_shift;
    logic [cce_block_width_p-1:0] uc_wr_block;
    logic [cce_block_width_p-1:0] wr_block;
    logic [cce_block_width_p-1:0] resp_data;
    logic [cnt_width_lp-1:0]      accept_latency;

    // Backing store; deliberately not cleared by reset
    logic [cce_block_width_p-1:0] mem [mem_els_p];

    assign cmd             = mem_cmd_i;
    assign mem_cmd_ready_o = ready_r;
    assign mem_resp_v_o    = resp_v_r;
    assign mem_resp_o      = resp_r;
    assign state_o         = state;

    // ready_r is only high in e_ready, so accept also implies the FSM is idle
    assign accept  = mem_cmd_v_i & ready_r & ~reset_i;

    // Higher address bits fall off here, which is what makes addresses alias
    assign blk_idx  = cmd.addr[lg_block_bytes_lp +: lg_mem_els_lp];
    assign byte_off = cmd.addr[0 +: lg_block_bytes_lp];
    assign rd_block = mem[blk_idx];

`ifdef BP_MEM_RESPONDER_RANDOM_LATENCY_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1) for latency jitter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign accept_latency = cnt_width_lp'(latency_p) + cnt_width_lp'(lfsr[2:0]);
`else
    assign accept_latency = cnt_width_lp'(latency_p);
`endif

    // Decode the command type into the write/known flags
    always_comb begin
        is_write   = 1'b0;
        known_type = 1'b1;
        case (cmd.msg_type)
            e_mem_msg_rd:    is_write = 1'b0;
            e_mem_msg_uc_rd: is_write = 1'b0;
            e_mem_msg_wr:    is_write = 1'b1;
            e_mem_msg_uc_wr: is_write = 1'b1;
            default:         known_type = 1'b0;
        endcase
    end

    // Byte-lane mask covering 2^size bytes; sizes larger than a block clamp to the block
    always_comb begin
        size_eff = (cmd.size > 3'(lg_block_bytes_lp)) ? 3'(lg_block_bytes_lp) : cmd.size;
        nbytes   = 32'd1 << size_eff;
        for (int i = 0; i < block_bytes_lp; i++) begin
            size_mask[i] = (32'(i) < nbytes);
        end
        wr_mask = size_mask << byte_off;
    end

    // Uncached read: bring the addressed bytes down to bit 0 and zero the rest
    always_comb begin
        rd_shift   = rd_block >> {byte_off, 3'b000};
        uc_rd_data = '0;
        for (int i = 0; i < block_bytes_lp; i++) begin
            uc_rd_data[i*8 +: 8] = size_mask[i] ? rd_shift[i*8 +: 8] : 8'h00;
        end
    end

    // Uncached write: merge the low bytes of the data field into the current block
    always_comb begin
        wr_shift    = cmd.data << {byte_off, 3'b000};
        uc_wr_block = rd_block;
        for (int i = 0; i < block_bytes_lp; i++) begin
            if (wr_mask[i]) begin
                uc_wr_block[i*8 +: 8] = wr_shift[i*8 +: 8];
            end
        end
    end

    // Choose the block that gets written and the data that gets returned
    always_comb begin
        wr_en     = accept & is_write;
        wr_block  = cmd.data;
        resp_data = rd_block;
        case (cmd.msg_type)
            e_mem_msg_wr: begin
                wr_block  = cmd.data;
                resp_data = '0;
            end
            e_mem_msg_uc_wr: begin
                wr_block  = uc_wr_block;
                resp_data = '0;
            end
            e_mem_msg_uc_rd: resp_data = uc_rd_data;
            default:         resp_data = rd_block;
        endcase
    end

    // Writes commit in the accept cycle so a following read sees them
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[blk_idx] <= wr_block;
        end
    end

    // Command/response FSM; the response is captured at accept and held until yumi
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= e_reset;
            ready_r  <= 1'b0;
            resp_v_r <= 1'b0;
            resp_r   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                e_reset: begin
                    state   <= e_ready;
                    ready_r <= 1'b1;
                end
                e_ready: begin
                    if (accept) begin
                        ready_r         <= 1'b0;
                        resp_r.msg_type <= cmd.msg_type;
                        resp_r.addr     <= cmd.addr;
                        resp_r.size     <= cmd.size;
                        resp_r.payload  <= cmd.payload;
                        resp_r.data     <= resp_data;
                        if (accept_latency <= cnt_one) begin
                            state    <= e_resp;
                            resp_v_r <= 1'b1;
                            cnt      <= '0;
                        end else begin
                            state <= e_wait;
                            cnt   <= accept_latency - cnt_one;
                        end
                    end
                end
                e_wait: begin
                    // cnt=1 here means the response is due next cycle
                    cnt <= (cnt == '0) ? '0 : cnt - cnt_one;
                    if (cnt <= cnt_one) begin
                        state    <= e_resp;
                        resp_v_r <= 1'b1;
                    end
                end
                e_resp: begin
                    if (mem_resp_yumi_i) begin
                        state    <= e_ready;
                        resp_v_r <= 1'b0;
                        ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state    <= e_reset;
                    ready_r  <= 1'b0;
                    resp_v_r <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flag commands this model does not understand; they are still served as block reads
    always_ff @(posedge clk_i) begin
        if (accept && !known_type) begin
            $error("bp_mem_cmd_responder: unrecognised msg_type %0h at addr %0h",
                   cmd.msg_type, cmd.addr);
        end
    end
`endif

endmodule

// File: tb/tb_bp_mem_cmd_responder.sv
// Self-checking bench for bp_mem_cmd_responder. Expected responses come from
// a byte-addressed reference memory kept in the bench and are queued per
// command; directed steps cover reset, block and uncached traffic, response
// back-pressure, reset mid-flight and address aliasing, followed by random
// traffic over a set of pre-written blocks.
module tb_bp_mem_cmd_responder;

    localparam int PADDR  = 40;
    localparam int BLK    = 512;
    localparam int PAY    = 16;
    localparam int ELS    = 1024;
    localparam int LAT    = 4;
    localparam int MSG_W  = 4 + PADDR + 3 + PAY + BLK;
    localparam int BYTES  = BLK / 8;
    localparam int STORE  = ELS * BYTES;

    localparam logic [3:0] T_RD   = 4'd0;
    localparam logic [3:0] T_WR   = 4'd1;
    localparam logic [3:0] T_UCRD = 4'd2;
    localparam logic [3:0] T_UCWR = 4'd3;

    logic             clk;
    logic             reset_i;
    logic [MSG_W-1:0] mem_cmd_i;
    logic             mem_cmd_v_i;
    logic             mem_cmd_ready_o;
    logic [MSG_W-1:0] mem_resp_o;
    logic             mem_resp_v_o;
    logic             mem_resp_yumi_i;
    logic [1:0]       dut_state;

    int total;
    int bad;

    logic [MSG_W-1:0] exp_q[$];
    logic [7:0]       ref_mem[int];

    bp_mem_cmd_responder #(
        .paddr_width_p    (PADDR),
        .cce_block_width_p(BLK),
        .payload_width_p  (PAY),
        .mem_els_p        (ELS),
        .latency_p        (LAT)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .mem_cmd_i      (mem_cmd_i),
        .mem_cmd_v_i    (mem_cmd_v_i),
        .mem_cmd_ready_o(mem_cmd_ready_o),
        .mem_resp_o     (mem_resp_o),
        .mem_resp_v_o   (mem_resp_v_o),
        .mem_resp_yumi_i(mem_resp_yumi_i),
        .state_o        (dut_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [MSG_W-1:0] obs, input logic [MSG_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [PADDR-1:0] a,
                                            input logic [2:0] sz, input logic [PAY-1:0] pl,
                                            input logic [BLK-1:0] d);
        return {t, a, sz, pl, d};
    endfunction

    function automatic logic [BLK-1:0] rand_block();
        logic [BLK-1:0] d;
        for (int i = 0; i < BLK / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [7:0] ref_rd(input int key);
        return ref_mem.exists(key) ? ref_mem[key] : 8'h00;
    endfunction

    // Reference: a flat byte memory of STORE bytes; addresses wrap modulo STORE
    function automatic logic [MSG_W-1:0] model_apply(input logic [MSG_W-1:0] msg);
        logic [3:0]       t;
        logic [PADDR-1:0] a;
        logic [2:0]       sz;
        logic [PAY-1:0]   pl;
        logic [BLK-1:0]   d;
        logic [BLK-1:0]   rd;
        int               base;
        int               off;
        int               n;
        {t, a, sz, pl, d} = msg;
        off  = int'(a % PADDR'(BYTES));
        base = int'(a % PADDR'(STORE)) - off;
        n    = 1 << sz;
        rd   = '0;
        case (t)
            T_WR:   for (int i = 0; i < BYTES; i++) ref_mem[base + i] = d[i*8 +: 8];
            T_UCWR: for (int i = 0; i < n; i++) ref_mem[base + off + i] = d[i*8 +: 8];
            T_UCRD: for (int i = 0; i < n; i++) rd[i*8 +: 8] = ref_rd(base + off + i);
            default: for (int i = 0; i < BYTES; i++) rd[i*8 +: 8] = ref_rd(base + i);
        endcase
        return {t, a, sz, pl, rd};
    endfunction

    // Reset driver: two cycles of reset, then check the one-cycle e_reset gap
    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", MSG_W'(mem_cmd_ready_o), '0);
        chk("rst_resp_v_low", MSG_W'(mem_resp_v_o), '0);
        chk("rst_resp_zero", mem_resp_o, '0);
        @(negedge clk);
        chk("rst_ready_high", MSG_W'(mem_cmd_ready_o), MSG_W'(1'b1));
        chk("rst_resp_v_idle", MSG_W'(mem_resp_v_o), '0);
    endtask

    // Command driver: wait (bounded) for ready, then present one command for one edge
    task automatic send_cmd(input logic [MSG_W-1:0] msg);
        int n;
        n = 0;
        @(negedge clk);
        while (mem_cmd_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", MSG_W'(mem_cmd_ready_o), MSG_W'(1'b1));
        if (mem_cmd_ready_o !== 1'b1) return;
        exp_q.push_back(model_apply(msg));
        mem_cmd_i   = msg;
        mem_cmd_v_i = 1'b1;
        @(posedge clk);
        #1;
        mem_cmd_v_i = 1'b0;
        mem_cmd_i   = '0;
    endtask

    // Response collector: measures latency, scores the response, optionally stalls yumi
    task automatic recv_resp(input int hold, output logic [MSG_W-1:0] got);
        int n;
        logic [MSG_W-1:0] exp;
        n   = 0;
        got = '0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_resp_v_o !== 1'b1 && n < 40);
        chk("resp_valid", MSG_W'(mem_resp_v_o), MSG_W'(1'b1));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (mem_resp_v_o !== 1'b1) return;
`ifdef BP_MEM_RESPONDER_RANDOM_LATENCY_EN
        chk("latency_window", MSG_W'(n >= LAT && n <= LAT + 7), MSG_W'(1'b1));
`else
        chk("latency", MSG_W'(n), MSG_W'(LAT));
`endif
        got = mem_resp_o;
        chk("resp_msg", got, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_resp_v", MSG_W'(mem_resp_v_o), MSG_W'(1'b1));
            chk("hold_resp_stable", mem_resp_o, exp);
            chk("hold_ready_low", MSG_W'(mem_cmd_ready_o), '0);
        end
        mem_resp_yumi_i = 1'b1;
        @(posedge clk);
        #1 mem_resp_yumi_i = 1'b0;
        @(negedge clk);
        chk("ready_after_yumi", MSG_W'(mem_cmd_ready_o), MSG_W'(1'b1));
        chk("resp_v_after_yumi", MSG_W'(mem_resp_v_o), '0);
    endtask

    task automatic do_op(input logic [MSG_W-1:0] msg, input int hold, output logic [MSG_W-1:0] got);
        send_cmd(msg);
        recv_resp(hold, got);
    endtask

    initial begin
        logic [MSG_W-1:0] got;
        logic [BLK-1:0]   pat;
        logic [BLK-1:0]   d;
        logic [PADDR-1:0] a;
        logic [PADDR-1:0] blks[$];
        logic [3:0]       t;
        logic [2:0]       sz;
        int               off;

        total           = 0;
        bad             = 0;
        mem_cmd_i       = '0;
        mem_cmd_v_i     = 1'b0;
        mem_resp_yumi_i = 1'b0;
        reset_i         = 1'b1;

        // Reset, then idle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ready", MSG_W'(mem_cmd_ready_o), MSG_W'(1'b1));
            chk("idle_resp_v", MSG_W'(mem_resp_v_o), '0);
        end

        // Full-block write then cached read of 0x80
        pat = {32{16'hDEAD}};
        do_op(mk(T_WR, 40'h80, 3'd6, 16'h0101, pat), 0, got);
        chk("wr80_data_zero", MSG_W'(got[BLK-1:0]), '0);
        do_op(mk(T_RD, 40'h80, 3'd6, 16'h0202, '0), 0, got);
        chk("rd80_data", MSG_W'(got[BLK-1:0]), MSG_W'(pat));
        chk("rd80_addr", MSG_W'(got[MSG_W-5 -: PADDR]), MSG_W'(40'h80));

        // 8-byte uncached write, then 4-byte uncached read from inside it
        d = '0;
        d[63:0] = 64'h1122334455667788;
        do_op(mk(T_UCWR, 40'h88, 3'd3, 16'h0303, d), 0, got);
        do_op(mk(T_UCRD, 40'h8C, 3'd2, 16'h0404, '0), 0, got);
        chk("ucrd_data", MSG_W'(got[BLK-1:0]), MSG_W'(32'h11223344));

        // Back-pressure: yumi withheld for 10 cycles
        do_op(mk(T_RD, 40'h80, 3'd0, 16'h0505, '0), 10, got);

        // Reset while the command is waiting: its response must never appear
        send_cmd(mk(T_RD, 40'h80, 3'd6, 16'h0606, '0));
        repeat (2) @(negedge clk);
        chk("midflight_resp_v", MSG_W'(mem_resp_v_o), '0);
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("dropped_resp_v", MSG_W'(mem_resp_v_o), '0);
        end
        do_op(mk(T_RD, 40'h80, 3'd6, 16'h0707, '0), 0, got);

        // Aliasing: 0x10000 and 0x0 land on the same block
        d = rand_block();
        do_op(mk(T_WR, 40'h10000, 3'd6, 16'h0808, d), 0, got);
        do_op(mk(T_RD, 40'h0, 3'd6, 16'h0909, '0), 0, got);
        chk("alias_data", MSG_W'(got[BLK-1:0]), MSG_W'(d));

        // Random traffic over blocks that have been fully written
        for (int k = 0; k < 8; k++) begin
            a = (PADDR'($urandom_range(0, 255)) << 16) | (PADDR'($urandom_range(0, ELS - 1)) << 6);
            blks.push_back(a);
            do_op(mk(T_WR, a, 3'd6, PAY'($urandom), rand_block()), 0, got);
        end
        for (int k = 0; k < 100; k++) begin
            a   = blks[$urandom_range(0, 7)];
            t   = 4'($urandom_range(0, 3));
            sz  = 3'($urandom_range(0, 6));
            off = $urandom_range(0, (BYTES >> sz) - 1) << sz;
            if (t == T_UCRD || t == T_UCWR) a = a + PADDR'(off);
            else a = a + PADDR'($urandom_range(0, BYTES - 1));
            do_op(mk(t, a, sz, PAY'($urandom), rand_block()), $urandom_range(0, 2), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
